// File: rtl/serial_pattern_gen.sv
// Serial test-stream source: shifts a latched DATA_W-bit word out MSB-first, one bit per DIV clocks,
// with GAP_BITS zero bit-periods after each word; one-shot or continuous repeat.
module serial_pattern_gen #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DIV      = 50,
   parameter int unsigned GAP_BITS = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              repeat_en,
   input  logic [DATA_W-1:0] pattern_in,
   output logic              data_out,
   output logic              bit_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BIT_W     = $clog2(DATA_W + GAP_BITS + 1);
   localparam int unsigned DIV_LAST  = DIV - 1;
   localparam int unsigned DATA_LAST = DATA_W - 1;
   localparam int unsigned GAP_LAST  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_shift;
   logic [DIV_W-1:0]    r_div_cnt;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic                r_data_out;
   logic                r_bit_valid;
   logic                r_busy;
   logic                r_done;

   state_t              w_state_nxt;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic [DIV_W-1:0]    w_div_nxt;
   logic [BIT_W-1:0]    w_bit_nxt;
   logic                w_data_nxt;
   logic                w_valid_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_load;
   logic                w_eow;
   logic                w_abort;
   logic                w_div_wrap;
   logic [DATA_W-1:0]   w_shift_sh;

   assign w_div_wrap = (r_div_cnt == DIV_W'(DIV_LAST));
   assign w_shift_sh = r_shift << 1;

   // State and datapath registers; every output comes straight from a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_div_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_data_out  <= 1'b0;
         r_bit_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_div_cnt   <= w_div_nxt;
         r_bit_cnt   <= w_bit_nxt;
         r_data_out  <= w_data_nxt;
         r_bit_valid <= w_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Next-state and next-output logic; load/end-of-word/abort resolved after the state case
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_div_nxt   = r_div_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_data_nxt  = r_data_out;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      w_eow       = 1'b0;
      w_abort     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_data_nxt = 1'b0;
            w_busy_nxt = 1'b0;
            if (start && !stop) begin
               w_load = 1'b1;
            end
         end

         S_SHIFT: begin
            if (stop) begin
               w_abort = 1'b1;
            end else if (w_div_wrap) begin
               w_div_nxt = '0;
               if (r_bit_cnt == BIT_W'(DATA_LAST)) begin
                  if (GAP_BITS > 0) begin
                     w_state_nxt = S_GAP;
                     w_bit_nxt   = '0;
                     w_data_nxt  = 1'b0;
                  end else begin
                     w_eow = 1'b1;
                  end
               end else begin
                  w_shift_nxt = w_shift_sh;
                  w_data_nxt  = w_shift_sh[DATA_W-1];
                  w_valid_nxt = 1'b1;
                  w_bit_nxt   = r_bit_cnt + BIT_W'(1);
               end
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end

         S_GAP: begin
            if (stop) begin
               w_abort = 1'b1;
            end else if (w_div_wrap) begin
               w_div_nxt = '0;
               if (r_bit_cnt == BIT_W'(GAP_LAST)) begin
                  w_eow = 1'b1;
               end else begin
                  w_bit_nxt = r_bit_cnt + BIT_W'(1);
               end
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end

         default: begin
            w_abort = 1'b1;
         end
      endcase

      // End of word: reload back-to-back when repeating, otherwise finish with a done pulse
      if (w_eow) begin
         if (repeat_en) begin
            w_load = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_data_nxt  = 1'b0;
            w_bit_nxt   = '0;
            w_div_nxt   = '0;
         end
      end

      if (w_load) begin
         w_state_nxt = S_SHIFT;
         w_shift_nxt = pattern_in;
         w_data_nxt  = pattern_in[DATA_W-1];
         w_valid_nxt = 1'b1;
         w_busy_nxt  = 1'b1;
         w_div_nxt   = '0;
         w_bit_nxt   = '0;
      end

      if (w_abort) begin
         w_state_nxt = S_IDLE;
         w_shift_nxt = '0;
         w_data_nxt  = 1'b0;
         w_valid_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_div_nxt   = '0;
         w_bit_nxt   = '0;
      end
   end

   assign data_out  = r_data_out;
   assign bit_valid = r_bit_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: three instances (DIV=1; DIV=4; DIV=1 with 2 gap bits)
// share one stimulus set; each scenario checks only the instance it targets.
module tb_serial_pattern_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       repeat_en;
   logic [4:0] pattern_in;

   logic a_d, a_v, a_b, a_done;
   logic b_d, b_v, b_b, b_done;
   logic c_d, c_v, c_b, c_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_pattern_gen #(.DATA_W(5), .DIV(1), .GAP_BITS(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(repeat_en),
      .pattern_in(pattern_in), .data_out(a_d), .bit_valid(a_v), .busy(a_b), .done(a_done));

   serial_pattern_gen #(.DATA_W(5), .DIV(4), .GAP_BITS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(repeat_en),
      .pattern_in(pattern_in), .data_out(b_d), .bit_valid(b_v), .busy(b_b), .done(b_done));

   serial_pattern_gen #(.DATA_W(5), .DIV(1), .GAP_BITS(2)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .repeat_en(repeat_en),
      .pattern_in(pattern_in), .data_out(c_d), .bit_valid(c_v), .busy(c_b), .done(c_done));

   // Vector record; exp packs {data_out, bit_valid, busy, done} after the clock edge
   typedef struct {
      logic       start;
      logic       stop;
      logic [4:0] pat;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got d/v/b/done=%b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      repeat_en  = 1'b0;
      pattern_in = 5'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // One full one-shot word on the DIV=4 instance, checked every clock
   task automatic run_b_word(input logic [4:0] pat, input string name);
      logic [3:0] exp;
      int idx;
      start      = 1'b1;
      pattern_in = pat;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         if (c <= 20) begin
            idx = (c - 1) / 4;
            exp = {pat[4 - idx], ((c - 1) % 4) == 0, 1'b1, 1'b0};
         end else if (c == 21) begin
            exp = 4'b0001;
         end else begin
            exp = 4'b0000;
         end
         check(name, {b_d, b_v, b_b, b_done}, exp);
         tick();
      end
   endtask

   initial begin
      logic [4:0] win;
      logic [3:0] exp;
      int         pos;
      int         finds;

      // One-shot 10010 at DIV=1, then mid-word start/pattern changes, then start&stop in IDLE
      tbl[0]  = '{1'b1, 1'b0, 5'b10010, 4'b1110};
      tbl[1]  = '{1'b0, 1'b0, 5'b10010, 4'b0110};
      tbl[2]  = '{1'b0, 1'b0, 5'b10010, 4'b0110};
      tbl[3]  = '{1'b0, 1'b0, 5'b10010, 4'b1110};
      tbl[4]  = '{1'b0, 1'b0, 5'b10010, 4'b0110};
      tbl[5]  = '{1'b0, 1'b0, 5'b10010, 4'b0001};
      tbl[6]  = '{1'b0, 1'b0, 5'b10010, 4'b0000};
      tbl[7]  = '{1'b1, 1'b0, 5'b10010, 4'b1110};
      tbl[8]  = '{1'b1, 1'b0, 5'b01101, 4'b0110};
      tbl[9]  = '{1'b0, 1'b0, 5'b01101, 4'b0110};
      tbl[10] = '{1'b1, 1'b0, 5'b11111, 4'b1110};
      tbl[11] = '{1'b0, 1'b0, 5'b11111, 4'b0110};
      tbl[12] = '{1'b0, 1'b0, 5'b11111, 4'b0001};
      tbl[13] = '{1'b0, 1'b0, 5'b11111, 4'b0000};
      tbl[14] = '{1'b1, 1'b1, 5'b11111, 4'b0000};
      tbl[15] = '{1'b0, 1'b0, 5'b11111, 4'b0000};

      do_reset();
      check("reset_a", {a_d, a_v, a_b, a_done}, 4'b0000);
      check("reset_b", {b_d, b_v, b_b, b_done}, 4'b0000);
      check("reset_c", {c_d, c_v, c_b, c_done}, 4'b0000);

      for (int i = 0; i < 16; i++) begin
         start      = tbl[i].start;
         stop       = tbl[i].stop;
         pattern_in = tbl[i].pat;
         tick();
         check($sformatf("tbl_%0d", i), {a_d, a_v, a_b, a_done}, tbl[i].exp);
      end
      start = 1'b0;
      stop  = 1'b0;

      // DIV=4 one-shot: 4 clocks per bit, done on clock 21
      do_reset();
      run_b_word(5'b10010, "div4_word");

      // Continuous repeat with 2 gap bits: period 7, one 10010 per period, never done
      do_reset();
      repeat_en  = 1'b1;
      pattern_in = 5'b10010;
      start      = 1'b1;
      tick();
      start = 1'b0;
      win   = 5'b0;
      finds = 0;
      for (int c = 1; c <= 21; c++) begin
         pos = (c - 1) % 7;
         if (pos < 5) exp = {pattern_in[4 - pos], 1'b1, 1'b1, 1'b0};
         else         exp = 4'b0010;
         check($sformatf("repeat_c%0d", c), {c_d, c_v, c_b, c_done}, exp);
         win = {win[3:0], c_d};
         if (win == 5'b10010) finds++;
         tick();
      end
      total++;
      if (finds != 3) begin
         bad++;
         $display("FAIL repeat_finds: got %0d want 3", finds);
      end
      repeat_en = 1'b0;
      stop      = 1'b1;
      tick();
      check("repeat_stop", {c_d, c_v, c_b, c_done}, 4'b0000);
      stop = 1'b0;
      tick();
      check("repeat_stop_idle", {c_d, c_v, c_b, c_done}, 4'b0000);

      // Stop on the first clock of the third bit at DIV=4: no done afterwards
      do_reset();
      pattern_in = 5'b11101;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("stop_pre", {b_d, b_v, b_b, b_done}, 4'b1110);
      stop = 1'b1;
      tick();
      check("stop_now", {b_d, b_v, b_b, b_done}, 4'b0000);
      stop = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("stop_after_%0d", k), {b_d, b_v, b_b, b_done}, 4'b0000);
      end

      // Asynchronous reset mid-word, then a fresh full word
      do_reset();
      pattern_in = 5'b10010;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("rst_pre", {b_d, b_v, b_b, b_done}, 4'b1010);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async", {b_d, b_v, b_b, b_done}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_b_word(5'b11001, "after_rst_word");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
